// File: rtl/hex_display_pkg.sv
// -----------------------------------------------------------------------------
// hex_display_pkg
// Shared definitions for the scrolling seven-segment message display:
//   - state_e      : controller FSM states (IDLE, RUN, PAUSE)
//   - SEG_BLANK    : all segments off (active-low), DP off
//   - SEG_TABLE    : nibble -> active-low segment pattern {DP, g..a}
//   - wrap_inc     : circular increment of a message index, wrapping past last
// -----------------------------------------------------------------------------
package hex_display_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Entry 15 is written first so SEG_TABLE[n] is the pattern for nibble n.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
    8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
    8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
    8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
  };

  // Next message index after v when the message ends at index last.
  function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] last);
    return (v == last) ? 4'd0 : v + 4'd1;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// -----------------------------------------------------------------------------
// hex7seg
// Combinational hex nibble to active-low seven-segment decoder (DP always off).
// Ports:
//   nibble_i [3:0]  value to display
//   seg_o    [7:0]  {DP, g, f, e, d, c, b, a}, active-low
// -----------------------------------------------------------------------------
module hex7seg
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/hex_scroll_ctrl.sv
// -----------------------------------------------------------------------------
// hex_scroll_ctrl
// Scrolls a message of up to 16 hex nibbles across six seven-segment digits.
// A 16-entry buffer is written while idle; start latches the message length
// and scrolls one position every TICK_DIV clocks; stop pauses, and stop again
// (or stop together with start) returns to idle.
// Ports:
//   CLOCK_50            clock, all state on rising edge
//   reset_n             synchronous active-low reset
//   wr_valid/wr_ready   buffer write handshake (ready only while idle)
//   wr_addr, wr_data    buffer entry index and nibble
//   msg_len             message length minus one, latched on start from idle
//   start, stop         scroll control (stop wins when both are high)
//   busy                controller not idle
//   HEX5..HEX0          registered active-low segments, HEX5 is leftmost
// -----------------------------------------------------------------------------
module hex_scroll_ctrl
  import hex_display_pkg::*;
#(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [3:0] msg_len,
  input  logic       start,
  input  logic       stop,
  output logic       busy,
  output logic [7:0] HEX5,
  output logic [7:0] HEX4,
  output logic [7:0] HEX3,
  output logic [7:0] HEX2,
  output logic [7:0] HEX1,
  output logic [7:0] HEX0
);

  localparam int unsigned     PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      pos_q,   pos_d;
  logic [3:0]      len_q,   len_d;
  logic            ready_q;
  logic [3:0]      buf_q [16];
  logic [7:0]      hex_q [6];
  logic [7:0]      hex_d [6];
  logic [3:0]      idx   [6];
  logic [7:0]      seg   [6];
  logic            launch;
  logic            tick;
  logic            wr_fire;

  // ---------------------------------------------------------------------------
  // FSM next state; stop is checked first so it overrides a simultaneous start.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin : fsm_next
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start && !stop) state_d = S_RUN;
      S_RUN:   if (stop)           state_d = S_PAUSE;
      S_PAUSE: begin
        if (stop)       state_d = S_IDLE;
        else if (start) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign launch  = (state_q == S_IDLE) && (state_d == S_RUN);
  assign tick    = (state_q == S_RUN) && (presc_q == PRESC_LAST);
  // ready_q is high exactly when the current state is IDLE (except the first
  // cycle after reset), so this also gates writes to idle only.
  assign wr_fire = wr_valid && ready_q;

  // ---------------------------------------------------------------------------
  // Prescaler / position / length. The prescaler counts in every RUN cycle,
  // including the one in which stop is sampled; PAUSE holds everything.
  // ---------------------------------------------------------------------------
  always_comb begin : scroll_next
    presc_d = presc_q;
    pos_d   = pos_q;
    len_d   = len_q;
    if (launch) begin
      presc_d = '0;
      pos_d   = '0;
      len_d   = msg_len;
    end else if (state_q == S_RUN) begin
      if (tick) begin
        presc_d = '0;
        pos_d   = (pos_q < len_q) ? pos_q + 4'd1 : 4'd0;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Window: digit k shows buf[(pos + k) mod (L + 1)]. Built as a chain of
  // circular increments instead of a modulo to avoid a divider.
  // ---------------------------------------------------------------------------
  always_comb begin : window_idx
    logic [3:0] p;
    p = pos_q;
    for (int k = 0; k < 6; k++) begin
      idx[k] = p;
      p      = wrap_inc(p, len_q);
    end
  end

  for (genvar k = 0; k < 6; k++) begin : g_digit
    hex7seg u_seg (
      .nibble_i (buf_q[idx[k]]),
      .seg_o    (seg[k])
    );
  end

  // Display follows the current state one cycle later; PAUSE freezes it.
  always_comb begin : hex_next
    for (int k = 0; k < 6; k++) begin
      hex_d[k] = SEG_BLANK;
      unique case (state_q)
        S_RUN:   hex_d[k] = seg[k];
        S_PAUSE: hex_d[k] = hex_q[k];
        default: hex_d[k] = SEG_BLANK;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge CLOCK_50) begin : ctrl_regs
    if (!reset_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      pos_q   <= '0;
      len_q   <= '0;
      ready_q <= 1'b0;
      for (int k = 0; k < 6; k++) hex_q[k] <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      pos_q   <= pos_d;
      len_q   <= len_d;
      ready_q <= (state_d == S_IDLE);
      for (int k = 0; k < 6; k++) hex_q[k] <= hex_d[k];
    end
  end

  // NOTE: the message buffer is a small flop array, not a RAM macro, so it is
  // reset; a start straight after reset therefore scrolls all zeros.
  always_ff @(posedge CLOCK_50) begin : buf_regs
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
    end else if (wr_fire) begin
      buf_q[wr_addr] <= wr_data;
    end
  end

  assign wr_ready = ready_q;
  assign busy     = (state_q != S_IDLE);
  assign HEX5     = hex_q[0];
  assign HEX4     = hex_q[1];
  assign HEX3     = hex_q[2];
  assign HEX2     = hex_q[3];
  assign HEX1     = hex_q[4];
  assign HEX0     = hex_q[5];

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hex_scroll_ctrl
// Self-checking bench for hex_scroll_ctrl with TICK_DIV = 4. A behavioural
// model steps on each rising edge and queues the expected outputs; a monitor
// on the falling edge pops and compares them. Directed scenarios also check
// literal segment patterns at fixed latencies.
// -----------------------------------------------------------------------------
module tb_hex_scroll_ctrl;

  localparam int TD = 4;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [3:0] wr_addr  = '0;
  logic [3:0] wr_data  = '0;
  logic [3:0] msg_len  = '0;
  logic       start    = 1'b0;
  logic       stop     = 1'b0;
  logic       busy;
  logic [7:0] HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hex_scroll_ctrl #(.TICK_DIV(TD)) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .msg_len  (msg_len),
    .start    (start),
    .stop     (stop),
    .busy     (busy),
    .HEX5     (HEX5),
    .HEX4     (HEX4),
    .HEX3     (HEX3),
    .HEX2     (HEX2),
    .HEX1     (HEX1),
    .HEX0     (HEX0)
  );

  wire [47:0] hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  localparam logic [47:0] ALL_BLANK = {6{8'hFF}};

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: message buffer, scroll position and step counter kept as
  // plain integers; the window is computed with a modulo.
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_RUN, M_PAUSE} mode_t;
  typedef struct packed {
    logic [47:0] hex;
    logic        busy;
    logic        rdy;
  } exp_t;

  mode_t       m_mode = M_IDLE;
  int          m_pos, m_cnt, m_len;
  logic [3:0]  m_buf [16];
  logic [47:0] m_hex;
  bit          m_rdy;
  exp_t        sb_q [$];

  function automatic logic [7:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [47:0] window();
    logic [47:0] w;
    for (int k = 0; k < 6; k++) w[47-8*k -: 8] = seg_of(m_buf[(m_pos + k) % (m_len + 1)]);
    return w;
  endfunction

  always @(posedge clk) begin : model_p
    exp_t        e;
    logic [47:0] nh;
    if (!reset_n) begin
      m_mode = M_IDLE;
      m_pos  = 0;
      m_cnt  = 0;
      m_len  = 0;
      for (int i = 0; i < 16; i++) m_buf[i] = '0;
      m_hex  = ALL_BLANK;
      m_rdy  = 1'b0;
    end else begin
      // Display shows the window of the state before this edge.
      if (m_mode == M_RUN)        nh = window();
      else if (m_mode == M_PAUSE) nh = m_hex;
      else                        nh = ALL_BLANK;
      if (m_mode == M_IDLE && m_rdy && wr_valid) m_buf[wr_addr] = wr_data;
      case (m_mode)
        M_IDLE: if (start && !stop) begin
          m_mode = M_RUN;
          m_pos  = 0;
          m_cnt  = 0;
          m_len  = int'(msg_len);
        end
        M_RUN: begin
          if (m_cnt == TD - 1) begin
            m_cnt = 0;
            m_pos = (m_pos < m_len) ? m_pos + 1 : 0;
          end else begin
            m_cnt++;
          end
          if (stop) m_mode = M_PAUSE;
        end
        default: begin
          if (stop)       m_mode = M_IDLE;
          else if (start) m_mode = M_RUN;
        end
      endcase
      m_hex = nh;
      m_rdy = (m_mode == M_IDLE);
    end
    e.hex  = m_hex;
    e.busy = (m_mode != M_IDLE);
    e.rdy  = m_rdy;
    sb_q.push_back(e);
  end

  // Monitor: outputs are all registered, so the falling edge is a safe sample.
  always @(negedge clk) begin : monitor_p
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("sb_hex",      hex_all,          e.hex);
      check("sb_busy",     48'(busy),        48'(e.busy));
      check("sb_wr_ready", 48'(wr_ready),    48'(e.rdy));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input logic [3:0] a, input logic [3:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    step(1);
    wr_valid = 1'b0;
  endtask

  task automatic pulse(input bit do_start, input bit do_stop);
    start = do_start; stop = do_stop;
    step(1);
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    step(3);
    check("reset_hex",   hex_all,       ALL_BLANK);
    check("reset_busy",  48'(busy),     48'd0);
    check("reset_ready", 48'(wr_ready), 48'd0);
    reset_n = 1'b1;
    step(1);
    check("ready_after_reset", 48'(wr_ready), 48'd1);

    // Basic scroll and wrap: 0..7, L = 7.
    for (int i = 0; i < 8; i++) write(4'(i), 4'(i));
    msg_len = 4'd7;
    pulse(1'b1, 1'b0);
    step(1);
    check("basic_pos0", hex_all, 48'hC0F9A4B09992);
    step(TD);
    check("basic_pos1", hex_all, 48'hF9A4B0999282);
    step(6 * TD);
    check("wrap_pos7",  hex_all, 48'hF8C0F9A4B099);
    step(TD);
    check("wrap_pos0",  hex_all, 48'hC0F9A4B09992);

    // Pause freezes the window; resume; then start+stop in PAUSE goes idle.
    pulse(1'b0, 1'b1);
    step(20);
    check("pause_frozen", hex_all,   48'hC0F9A4B09992);
    check("pause_busy",   48'(busy), 48'd1);
    pulse(1'b1, 1'b0);
    step(2 * TD + 1);
    pulse(1'b0, 1'b1);
    step(2);
    pulse(1'b1, 1'b1);
    step(1);
    check("both_to_idle_hex",  hex_all,   ALL_BLANK);
    check("both_to_idle_busy", 48'(busy), 48'd0);

    // Writes during RUN are refused and leave the buffer untouched.
    pulse(1'b1, 1'b0);
    wr_valid = 1'b1; wr_addr = 4'd0; wr_data = 4'hF;
    step(3);
    check("run_ready_low", 48'(wr_ready), 48'd0);
    wr_valid = 1'b0;
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    step(2);
    pulse(1'b1, 1'b0);
    step(1);
    check("write_blocked", hex_all, 48'hC0F9A4B09992);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    step(1);

    // Short message 1,2,3 with the last write in the same cycle as start.
    write(4'd0, 4'd1);
    write(4'd1, 4'd2);
    msg_len  = 4'd2;
    wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 4'd3; start = 1'b1;
    step(1);
    wr_valid = 1'b0; start = 1'b0;
    step(1);
    check("short_pos0", hex_all, 48'hF9A4B0F9A4B0);
    step(TD);
    check("short_pos1", hex_all, 48'hA4B0F9A4B0F9);

    // Reset in the middle of RUN.
    step(3);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    check("midrun_reset_hex",  hex_all,   ALL_BLANK);
    check("midrun_reset_busy", 48'(busy), 48'd0);
    step(1);
    msg_len = 4'd0;
    pulse(1'b1, 1'b0);
    step(1);
    check("buf_cleared", hex_all, {6{8'hC0}});
    step(2 * TD);
    check("len1_hold", hex_all, {6{8'hC0}});
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);

    // Randomized traffic, scoreboard only.
    for (int n = 0; n < 1500; n++) begin
      reset_n  = ($urandom_range(0, 299) != 0);
      start    = ($urandom_range(0, 11) == 0);
      stop     = ($urandom_range(0, 17) == 0);
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_addr  = 4'($urandom_range(0, 15));
      wr_data  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) msg_len = 4'($urandom_range(0, 15));
      step(1);
    end
    reset_n = 1'b1; start = 1'b0; stop = 1'b0; wr_valid = 1'b0;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
